binary_neuron_fp16: RTL and testbench
=====================================

// Module: binary_neuron_fp16
// PURPOSE
//   Parametrised FP16 neuron for binarised inputs: out = act(bias + sum of weight[i] over i where image[i]==1).
//   Successor of the fixed 64-input hidden neuron. Adds width parameters, a start/busy/done handshake,
//   a bias input and a runtime ReLU/identity select, and re-runs without reset.
//   Zero input bits are skipped in 1 cycle each. Sits in the hidden layer between the image buffer and the output layer.
//   Accumulation uses the shared fp16_mac with mul_in2 tied to 16'h3C00 (1.0).
// PARAMETERS
//   N_IN     64   number of binary inputs and weights; legal range 1..1024
//   MAC_LAT  3    fp16_mac latency in cycles; >=1; must match the instantiated MAC
//   IDX_W    $clog2(N_IN) (min 1)   index counter width; derived, not overridden
// PORTS
//   clk          in   1          clock
//   rst          in   1          synchronous, active-high reset
//   start        in   1          request; accepted only when busy==0
//   image        in   N_IN       binary input vector; captured on accept
//   weight_flat  in   16*N_IN    FP16 weights; weight[i] = weight_flat[i*16 +: 16]
//   bias         in   16         FP16 initial accumulator value; captured on accept
//   act_relu     in   1          1 = ReLU, 0 = identity; captured on accept
//   busy         out  1          high from the cycle after accept until done is asserted
//   done         out  1          one-cycle pulse; result is valid in the same cycle
//   result       out  16         FP16 neuron output; held until the next done or rst
// BEHAVIOUR
//   Reset: state=IDLE, idx=0, acc=0, busy=0, done=0, result=16'h0000.
//          rst dominates every state. Reset mid-operation aborts silently, with no done pulse.
//   FSM:
//     IDLE: start=1 -> capture image, bias, act_relu; acc<=bias; idx<=0; busy<=1; go to SCAN.
//     SCAN: image_q[idx]==1 -> drive MAC (mul_in1=weight[idx], acc_in=acc); go to WAIT.
//           image_q[idx]==0 -> if idx==N_IN-1 go to ACT, else idx<=idx+1 and stay in SCAN.
//     WAIT: hold MAC inputs for MAC_LAT-1 cycles (0 cycles when MAC_LAT==1), then go to ACC.
//     ACC:  acc<=mac_out. Then if idx==N_IN-1 go to ACT, else idx<=idx+1 and go to SCAN.
//     ACT:  result<=(act_relu && acc[15]) ? 16'h0000 : acc; done<=1; busy<=0; go to IDLE.
//   MAC input outside SCAN/WAIT: mul_in1 forced to 16'h0000. mac_out is sampled only in ACC.
//   Latency: with Z zero bits and K one bits, done rises 2+Z+K*(MAC_LAT+1) cycles after the accept edge.
//     N_IN=64, MAC_LAT=3, all zeros -> 66 cycles.
//     N_IN=64, MAC_LAT=3, all ones  -> 258 cycles.
//   Handshake:
//     - start while busy is ignored; no queueing.
//     - start in the done cycle is accepted (FSM is already in IDLE), giving back-to-back runs.
//   Weights are not captured. The source holds weight_flat stable from accept to done.
//   image, bias and act_relu may change freely after accept.
//   ReLU clamps -0.0 (8000) and negative NaN to 0000. Positive NaN/Inf pass through. No other sanitising.
//   Arithmetic: accumulation order is i=0..N_IN-1. Rounding is whatever fp16_mac does (one rounding per add).
//   Boundaries:
//     - idx never exceeds N_IN-1 and never wraps.
//     - N_IN=1 is legal.
//     - Empty image gives result=act(bias).
// TESTING
//   1 N_IN=64, image=0, bias=3C00, relu=1, start -> done at +66 cycles, result=3C00, busy high for cycles 1..65.
//   2 image=all ones, all weights=3C00, bias=0000 -> result=5400 (64.0), done at +258 cycles.
//   3 image bits 0 and 2 only, w0=4000, w2=BC00, bias=3800 -> result=3E00 (1.5), done at +72 cycles.
//   4 image bit0 only, w0=C000, bias=0000: relu=1 -> 0000; relu=0 -> C000; bias=8000 with empty image, relu=1 -> 0000.
//   5 start pulsed while busy -> ignored, result unchanged; start in the done cycle -> second run accepted, correct result.
//   6 rst at cycle 10 of a run -> next cycle busy=0, done=0, result=0000, no done pulse; a fresh start then gives the correct value.
//   Also run N_IN=1 with MAC_LAT=1 on a single-bit image, and check the latency formula against the bench counter.

Source files
------------

// File: rtl/binary_neuron_fp16_if.sv
// rtl/binary_neuron_fp16_if.sv - request/response bundle between a neuron and its controller
interface binary_neuron_fp16_if #(
  parameter int N_IN = 64
);
  logic                 start;
  logic [N_IN-1:0]      image;
  logic [16*N_IN-1:0]   weight_flat;
  logic [15:0]          bias;
  logic                 act_relu;
  logic                 busy;
  logic                 done;
  logic [15:0]          result;

  modport master (
    output start, image, weight_flat, bias, act_relu,
    input  busy, done, result
  );

  modport slave (
    input  start, image, weight_flat, bias, act_relu,
    output busy, done, result
  );
endinterface

// File: rtl/binary_neuron_fp16.sv
// rtl/binary_neuron_fp16.sv - FP16 neuron over binarised inputs with a fused fp16 MAC
// Fused multiply-add: exact sum in wide fixed point, then a single round-to-nearest-even.
module fp16_mac #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mul_in1,
  input  logic [15:0] mul_in2,
  input  logic [15:0] acc_in,
  output logic [15:0] mac_out
);
  function automatic logic [10:0] sig_of(input logic [14:0] x);
    return (x[14:10] == 5'd0) ? {1'b0, x[9:0]} : {1'b1, x[9:0]};
  endfunction

  function automatic logic [4:0] exp_of(input logic [14:0] x);
    return (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
  endfunction

  logic        sp, sa, nan_any, pinf, ainf;
  logic [81:0] pmag, amag, mag;
  logic [82:0] pterm, aterm, sum;
  logic [6:0]  p, sh;
  logic [11:0] q, rnd;
  logic        guard, sticky;
  logic [31:0] enc;
  logic [15:0] res;
  logic [15:0] pipe [LAT];

  // Exact product and addend on a 2^-48 grid, add, normalise, round once.
  always_comb begin
    sp    = mul_in1[15] ^ mul_in2[15];
    sa    = acc_in[15];
    pmag  = (82'(sig_of(mul_in1[14:0])) * 82'(sig_of(mul_in2[14:0])))
            << (32'(exp_of(mul_in1[14:0])) + 32'(exp_of(mul_in2[14:0])) - 2);
    amag  = 82'(sig_of(acc_in[14:0])) << (32'(exp_of(acc_in[14:0])) + 23);
    pterm = sp ? -{1'b0, pmag} : {1'b0, pmag};
    aterm = sa ? -{1'b0, amag} : {1'b0, amag};
    sum   = pterm + aterm;
    mag   = 82'(sum[82] ? -sum : sum);
    p = 7'd0;
    for (int i = 0; i < 82; i++) if (mag[i]) p = 7'(i);
    sh     = (p >= 7'd34) ? p - 7'd10 : 7'd24;
    q      = 12'(mag >> sh);
    guard  = mag[sh - 7'd1];
    sticky = |(mag & ((82'(1) << (sh - 7'd1)) - 82'(1)));
    rnd    = q + {11'b0, guard & (sticky | q[0])};
    enc    = (((p >= 7'd34) ? 32'(p - 7'd34) : 32'd0) << 10) + 32'(rnd);
    pinf   = (mul_in1[14:0] == 15'h7C00) || (mul_in2[14:0] == 15'h7C00);
    ainf   = (acc_in[14:0] == 15'h7C00);
    nan_any = (mul_in1[14:10] == 5'h1F && mul_in1[9:0] != 10'd0)
           || (mul_in2[14:10] == 5'h1F && mul_in2[9:0] != 10'd0)
           || (acc_in[14:10] == 5'h1F && acc_in[9:0] != 10'd0)
           || (pinf && (mul_in1[14:0] == 15'd0 || mul_in2[14:0] == 15'd0))
           || (pinf && ainf && (sp != sa));
    if (nan_any)                res = 16'h7E00;
    else if (pinf)              res = {sp, 15'h7C00};
    else if (ainf)              res = {sa, 15'h7C00};
    else if (mag == 82'd0)      res = {sp & sa, 15'h0000};
    else if (enc >= 32'h7C00)   res = {sum[82], 15'h7C00};
    else                        res = {sum[82], enc[14:0]};
  end

  // Latency pipeline so the result appears LAT cycles after the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 16'h0000;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mac_out = pipe[LAT-1];
endmodule

module binary_neuron_fp16 #(
  parameter int N_IN    = 64,
  parameter int MAC_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  binary_neuron_fp16_if.slave  nrn
);
  localparam int IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int WAIT_LAST = (MAC_LAT > 1) ? MAC_LAT - 2 : 0;

  typedef enum logic [2:0] {IDLE, SCAN, WAIT, ACC, ACT} state_t;
  state_t state, state_nx;

  logic [N_IN-1:0]  image_q;
  logic             relu_q;
  logic [15:0]      acc;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wcnt;
  logic             busy_r, done_r;
  logic [15:0]      result_r;
  logic             last;
  logic [15:0]      wsel, mul_in1, mac_out;

  assign last       = (idx == IDX_W'(N_IN - 1));
  assign wsel       = nrn.weight_flat[32'(idx)*16 +: 16];
  assign nrn.busy   = busy_r;
  assign nrn.done   = done_r;
  assign nrn.result = result_r;

  // State register; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: skip zero bits in one cycle, spend MAC_LAT+1 cycles on one bits.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (nrn.start) state_nx = SCAN;
      SCAN: begin
        if (image_q[idx])  state_nx = (MAC_LAT == 1) ? ACC : WAIT;
        else if (last)     state_nx = ACT;
      end
      WAIT: if (wcnt == CNT_W'(WAIT_LAST)) state_nx = ACC;
      ACC:  state_nx = last ? ACT : SCAN;
      ACT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // MAC operand: selected weight only while an add is in flight, zero otherwise.
  always_comb begin
    mul_in1 = 16'h0000;
    if ((state == SCAN && image_q[idx]) || state == WAIT) mul_in1 = wsel;
  end

  // Datapath: capture on accept, walk the index, accumulate, apply activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      image_q  <= '0;
      relu_q   <= 1'b0;
      acc      <= 16'h0000;
      idx      <= '0;
      wcnt     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 16'h0000;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (nrn.start) begin
          image_q <= nrn.image;
          relu_q  <= nrn.act_relu;
          acc     <= nrn.bias;
          idx     <= '0;
          busy_r  <= 1'b1;
        end
        SCAN: begin
          wcnt <= '0;
          if (!image_q[idx] && !last) idx <= idx + IDX_W'(1);
        end
        WAIT: wcnt <= wcnt + CNT_W'(1);
        ACC: begin
          acc <= mac_out;
          if (!last) idx <= idx + IDX_W'(1);
        end
        ACT: begin
          result_r <= (relu_q && acc[15]) ? 16'h0000 : acc;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fp16_mac #(.LAT(MAC_LAT)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .mul_in1 (mul_in1),
    .mul_in2 (16'h3C00),
    .acc_in  (acc),
    .mac_out (mac_out)
  );
endmodule

// File: tb/tb_binary_neuron_fp16.sv
// tb/tb_binary_neuron_fp16.sv - directed self-checking bench for binary_neuron_fp16
module tb_binary_neuron_fp16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_neuron_fp16_if #(.N_IN(64)) m();
  binary_neuron_fp16_if #(.N_IN(1))  s();

  binary_neuron_fp16 #(.N_IN(64), .MAC_LAT(3)) dut_m (.clk(clk), .rst(rst), .nrn(m));
  binary_neuron_fp16 #(.N_IN(1),  .MAC_LAT(1)) dut_s (.clk(clk), .rst(rst), .nrn(s));

  int checks   = 0;
  int failures = 0;
  int cyc, blo, dcnt;
  logic [63:0] img3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_w(input logic [15:0] w);
    for (int i = 0; i < 64; i++) m.weight_flat[i*16 +: 16] = w;
  endtask

  // Called at a negedge; start is seen by the next posedge (the accept edge).
  task automatic launch_m(input logic [63:0] img, input logic [15:0] b, input logic r);
    m.image = img; m.bias = b; m.act_relu = r; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
  endtask

  task automatic wait_m(input int c0, output int c, output int busy_low);
    c = c0; busy_low = 0;
    while (!m.done && c < 400) begin
      if (!m.busy) busy_low++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_m(input string tag, input logic [63:0] img, input logic [15:0] b,
                       input logic r, input logic [15:0] exp_res, input int exp_lat);
    int c, bl;
    @(negedge clk);
    launch_m(img, b, r);
    wait_m(1, c, bl);
    check({tag, "_lat"}, c, exp_lat);
    check({tag, "_res"}, m.result, exp_res);
    check({tag, "_busylow"}, bl, 0);
    check({tag, "_busy_at_done"}, m.busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, m.done, 0);
  endtask

  task automatic run_s(input string tag, input logic img, input logic [15:0] b,
                       input logic r, input logic [15:0] exp_res, input int exp_lat);
    int c;
    @(negedge clk);
    s.image = img; s.bias = b; s.act_relu = r; s.start = 1'b1;
    @(negedge clk);
    s.start = 1'b0;
    c = 1;
    while (!s.done && c < 50) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, c, exp_lat);
    check({tag, "_res"}, s.result, exp_res);
  endtask

  initial begin
    rst = 1'b1;
    m.start = 0; m.image = '0; m.bias = '0; m.act_relu = 0; m.weight_flat = '0;
    s.start = 0; s.image = '0; s.bias = '0; s.act_relu = 0; s.weight_flat = 16'h3C00;
    img3 = 64'h5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", m.busy, 0);
    check("rst_done", m.done, 0);
    check("rst_result", m.result, 16'h0000);
    check("rst_s_result", s.result, 16'h0000);

    fill_w(16'h3C00);
    run_m("t1_empty", 64'h0, 16'h3C00, 1'b1, 16'h3C00, 66);
    run_m("t2_ones", {64{1'b1}}, 16'h0000, 1'b0, 16'h5400, 258);

    m.weight_flat[0 +: 16] = 16'h4000;
    m.weight_flat[32 +: 16] = 16'hBC00;
    run_m("t3_two", img3, 16'h3800, 1'b1, 16'h3E00, 72);

    fill_w(16'h3C00);
    m.weight_flat[0 +: 16] = 16'hC000;
    run_m("t4_relu", 64'h1, 16'h0000, 1'b1, 16'h0000, 69);
    run_m("t4_ident", 64'h1, 16'h0000, 1'b0, 16'hC000, 69);
    run_m("t4_negzero", 64'h0, 16'h8000, 1'b1, 16'h0000, 66);
    run_m("t4_negzero_id", 64'h0, 16'h8000, 1'b0, 16'h8000, 66);

    // Start while busy is ignored; start in the done cycle is accepted.
    fill_w(16'h3C00);
    m.weight_flat[0 +: 16] = 16'h4000;
    m.weight_flat[32 +: 16] = 16'hBC00;
    @(negedge clk);
    launch_m(img3, 16'h3800, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_hold_result", m.result, 16'h8000);
    m.image = 64'h0; m.bias = 16'h4000; m.act_relu = 1'b0; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    wait_m(6, cyc, blo);
    check("t5_ign_lat", cyc, 72);
    check("t5_ign_res", m.result, 16'h3E00);
    m.image = 64'h0; m.bias = 16'h4400; m.act_relu = 1'b0; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    wait_m(1, cyc, blo);
    check("t5_b2b_lat", cyc, 66);
    check("t5_b2b_res", m.result, 16'h4400);
    check("t5_b2b_busylow", blo, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    launch_m(img3, 16'h3800, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", m.busy, 0);
    check("t6_done", m.done, 0);
    check("t6_result", m.result, 16'h0000);
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (m.done) dcnt++;
    end
    check("t6_no_done", dcnt, 0);
    run_m("t6_fresh", img3, 16'h3800, 1'b1, 16'h3E00, 72);

    // Single-input neuron with a one-cycle MAC.
    run_s("s_one", 1'b1, 16'h3C00, 1'b0, 16'h4000, 4);
    run_s("s_zero_relu", 1'b0, 16'hBC00, 1'b1, 16'h0000, 3);
    run_s("s_zero_id", 1'b0, 16'hBC00, 1'b0, 16'hBC00, 3);
    run_s("s_cancel", 1'b1, 16'hBC00, 1'b0, 16'h0000, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
